// File: rtl/kbd_scancode_decoder.sv
// kbd_scancode_decoder
//
// Sits directly behind ps2_keyboard. It pops PS/2 set-2 scan bytes from the
// keyboard FIFO, folds E0/F0 prefixes into make/break events, and tracks the
// currently held key for display on the seven-segment driver.
//
// Ports:
//   clk            in   system clock, same domain as ps2_keyboard
//   resetn         in   synchronous active-low reset
//   kbd_data       in   [7:0] FIFO head byte
//   kbd_ready      in   FIFO non-empty
//   kbd_overflow   in   FIFO overflow flag
//   kbd_nextdata_n out  active-low pop strobe, low for one cycle per byte
//   key_code       out  [7:0] scan code of the last make event
//   key_ascii      out  [7:0] ASCII of key_code, 0x00 if unmapped/extended
//   key_ext        out  last make event carried an E0 prefix
//   key_pressed    out  a key is currently held
//   key_valid      out  one-cycle pulse per make event (repeats included)
//   press_count    out  [7:0] wrapping count of new presses
//   err_overflow   out  sticky copy of kbd_overflow
//
// Build option:
//   KBD_ASCII_EN   when defined, a scan-to-ASCII ROM drives key_ascii;
//                  otherwise key_ascii is tied to 0x00.

module kbd_scancode_decoder (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] kbd_data,
    input  logic       kbd_ready,
    input  logic       kbd_overflow,
    output logic       kbd_nextdata_n,
    output logic [7:0] key_code,
    output logic [7:0] key_ascii,
    output logic       key_ext,
    output logic       key_pressed,
    output logic       key_valid,
    output logic [7:0] press_count,
    output logic       err_overflow
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_POP    = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t     state, state_next;

    logic [7:0] rx_byte, rx_byte_next;
    logic       brk_flag, brk_flag_next;
    logic       ext_flag, ext_flag_next;

    logic       nextdata_n_next;
    logic [7:0] key_code_next;
    logic       key_ext_next;
    logic       key_pressed_next;
    logic       key_valid_next;
    logic [7:0] press_count_next;
    logic       new_press;

    // State and all registered outputs. Every output comes straight from a
    // flop so there is no combinational path from the FIFO to the display.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= S_IDLE;
            rx_byte        <= 8'h00;
            brk_flag       <= 1'b0;
            ext_flag       <= 1'b0;
            kbd_nextdata_n <= 1'b1;
            key_code       <= 8'h00;
            key_ext        <= 1'b0;
            key_pressed    <= 1'b0;
            key_valid      <= 1'b0;
            press_count    <= 8'h00;
            err_overflow   <= 1'b0;
        end else begin
            state          <= state_next;
            rx_byte        <= rx_byte_next;
            brk_flag       <= brk_flag_next;
            ext_flag       <= ext_flag_next;
            kbd_nextdata_n <= nextdata_n_next;
            key_code       <= key_code_next;
            key_ext        <= key_ext_next;
            key_pressed    <= key_pressed_next;
            key_valid      <= key_valid_next;
            press_count    <= press_count_next;
            err_overflow   <= err_overflow | kbd_overflow;
        end
    end

    // Next-state and decode. The SETTLE state gives the FIFO one cycle to
    // move its read pointer after the pop, so kbd_ready is never seen stale
    // and the pop strobe can never be low on two consecutive cycles.
    always_comb begin
        state_next       = state;
        rx_byte_next     = rx_byte;
        brk_flag_next    = brk_flag;
        ext_flag_next    = ext_flag;
        nextdata_n_next  = 1'b1;
        key_code_next    = key_code;
        key_ext_next     = key_ext;
        key_pressed_next = key_pressed;
        key_valid_next   = 1'b0;
        press_count_next = press_count;
        new_press        = 1'b0;

        case (state)
            S_IDLE: begin
                if (kbd_ready) begin
                    rx_byte_next    = kbd_data;
                    nextdata_n_next = 1'b0;
                    state_next      = S_POP;
                end
            end

            S_POP: begin
                state_next = S_SETTLE;
                if (rx_byte == 8'hF0) begin
                    brk_flag_next = 1'b1;
                end else if (rx_byte == 8'hE0) begin
                    ext_flag_next = 1'b1;
                end else if (brk_flag) begin
                    // A break only releases the key we think is held; a
                    // stale break from a replaced key is ignored.
                    if (rx_byte == key_code && ext_flag == key_ext)
                        key_pressed_next = 1'b0;
                    brk_flag_next = 1'b0;
                    ext_flag_next = 1'b0;
                end else begin
                    if (key_pressed && rx_byte == key_code && ext_flag == key_ext) begin
                        // Typematic repeat of the held key.
                        key_valid_next = 1'b1;
                    end else begin
                        new_press        = 1'b1;
                        key_code_next    = rx_byte;
                        key_ext_next     = ext_flag;
                        key_pressed_next = 1'b1;
                        key_valid_next   = 1'b1;
                        press_count_next = press_count + 8'd1;
                    end
                    brk_flag_next = 1'b0;
                    ext_flag_next = 1'b0;
                end
            end

            S_SETTLE: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

`ifdef KBD_ASCII_EN
    // Set-2 scan code to ASCII. Extended (E0) codes never map.
    function automatic logic [7:0] scan_to_ascii(input logic [7:0] code,
                                                 input logic       ext);
        logic [7:0] a;
        a = 8'h00;
        if (!ext) begin
            case (code)
                8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;
                8'h23: a = 8'h64;  8'h24: a = 8'h65;  8'h2B: a = 8'h66;
                8'h34: a = 8'h67;  8'h33: a = 8'h68;  8'h43: a = 8'h69;
                8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
                8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;
                8'h4D: a = 8'h70;  8'h15: a = 8'h71;  8'h2D: a = 8'h72;
                8'h1B: a = 8'h73;  8'h2C: a = 8'h74;  8'h3C: a = 8'h75;
                8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
                8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
                8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;
                8'h26: a = 8'h33;  8'h25: a = 8'h34;  8'h2E: a = 8'h35;
                8'h36: a = 8'h36;  8'h3D: a = 8'h37;  8'h3E: a = 8'h38;
                8'h46: a = 8'h39;
                8'h29: a = 8'h20;  8'h5A: a = 8'h0D;
                default: a = 8'h00;
            endcase
        end
        return a;
    endfunction

    logic [7:0] ascii_q;

    // The ASCII value only changes together with key_code on a new press.
    always_ff @(posedge clk) begin
        if (!resetn)
            ascii_q <= 8'h00;
        else if (new_press)
            ascii_q <= scan_to_ascii(rx_byte, ext_flag);
    end

    assign key_ascii = ascii_q;
`else
    assign key_ascii = 8'h00;
`endif

endmodule

// File: tb/tb_kbd_scancode_decoder.sv
// tb_kbd_scancode_decoder
//
// Directed bench for kbd_scancode_decoder. A small FIFO model stands in for
// ps2_keyboard: tasks append bytes, and the model pops on each cycle the
// decoder holds kbd_nextdata_n low. A monitor records pop cycles and counts
// key_valid pulses so tasks can compare them against hand-computed values.

module tb_kbd_scancode_decoder;

`ifdef KBD_ASCII_EN
    localparam bit ASCII_EN = 1'b1;
`else
    localparam bit ASCII_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] kbd_data = 8'h00;
    logic       kbd_ready = 1'b0;
    logic       kbd_overflow = 1'b0;
    logic       kbd_nextdata_n;
    logic [7:0] key_code;
    logic [7:0] key_ascii;
    logic       key_ext;
    logic       key_pressed;
    logic       key_valid;
    logic [7:0] press_count;
    logic       err_overflow;

    int total = 0;
    int bad = 0;

    logic [7:0] fifo_mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pop_cycles [$];
    int valid_cnt = 0;
    int double_low = 0;
    int cycle = 0;
    logic prev_low = 1'b0;

    kbd_scancode_decoder dut (
        .clk            (clk),
        .resetn         (resetn),
        .kbd_data       (kbd_data),
        .kbd_ready      (kbd_ready),
        .kbd_overflow   (kbd_overflow),
        .kbd_nextdata_n (kbd_nextdata_n),
        .key_code       (key_code),
        .key_ascii      (key_ascii),
        .key_ext        (key_ext),
        .key_pressed    (key_pressed),
        .key_valid      (key_valid),
        .press_count    (press_count),
        .err_overflow   (err_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // FIFO model and monitor, evaluated mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (!resetn) begin
            rd_ptr = wr_ptr;
        end else if (!kbd_nextdata_n) begin
            pop_cycles.push_back(cycle);
            if (prev_low) double_low++;
            if (rd_ptr != wr_ptr) rd_ptr++;
        end
        prev_low = !kbd_nextdata_n;
        if (key_valid) valid_cnt++;
        kbd_ready = (rd_ptr != wr_ptr);
        kbd_data  = (rd_ptr != wr_ptr) ? fifo_mem[rd_ptr % 1024] : 8'h00;
    end

    function automatic logic [7:0] exp_ascii(input logic [7:0] a);
        return ASCII_EN ? a : 8'h00;
    endfunction

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr % 1024] = b;
        wr_ptr++;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 resetn = 1'b0;
        kbd_overflow = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    // Wait for the FIFO to empty (bounded), then let the last byte decode.
    task automatic drain(input int limit);
        int n;
        n = 0;
        while (rd_ptr != wr_ptr && n < limit) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (rd_ptr != wr_ptr) begin
            bad++;
            $display("[TB] FAIL drain_timeout: remaining=%0d required=0", wr_ptr - rd_ptr);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if (kbd_nextdata_n !== 1'b1) begin bad++; $display("[TB] FAIL reset_nextdata_n: got=%b want=1", kbd_nextdata_n); end
        total++;
        if ({key_code, key_ascii, press_count} !== 24'h0) begin bad++; $display("[TB] FAIL reset_bytes: got=%h want=000000", {key_code, key_ascii, press_count}); end
        total++;
        if ({key_ext, key_pressed, key_valid, err_overflow} !== 4'b0) begin bad++; $display("[TB] FAIL reset_flags: got=%b want=0000", {key_ext, key_pressed, key_valid, err_overflow}); end
    endtask

    task automatic test_first_press();
        int pb, vb;
        pb = pop_cycles.size();
        vb = valid_cnt;
        @(posedge clk); #1 push(8'h1C);
        drain(100);
        total++;
        if (pop_cycles.size() - pb !== 1) begin bad++; $display("[TB] FAIL first_pop_cycles: got=%0d want=1", pop_cycles.size() - pb); end
        total++;
        if (valid_cnt - vb !== 1) begin bad++; $display("[TB] FAIL first_valid_pulse: got=%0d want=1", valid_cnt - vb); end
        total++;
        if (key_code !== 8'h1C) begin bad++; $display("[TB] FAIL first_code: got=%h want=1c", key_code); end
        total++;
        if (key_pressed !== 1'b1) begin bad++; $display("[TB] FAIL first_pressed: got=%b want=1", key_pressed); end
        total++;
        if (press_count !== 8'd1) begin bad++; $display("[TB] FAIL first_count: got=%0d want=1", press_count); end
        total++;
        if (key_ascii !== exp_ascii(8'h61)) begin bad++; $display("[TB] FAIL first_ascii: got=%h want=%h", key_ascii, exp_ascii(8'h61)); end
    endtask

    task automatic test_typematic();
        int vb;
        vb = valid_cnt;
        @(posedge clk); #1;
        push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
        drain(100);
        total++;
        if (valid_cnt - vb !== 3) begin bad++; $display("[TB] FAIL repeat_valid: got=%0d want=3", valid_cnt - vb); end
        total++;
        if (press_count !== 8'd1) begin bad++; $display("[TB] FAIL repeat_count: got=%0d want=1", press_count); end
        total++;
        if (key_pressed !== 1'b0) begin bad++; $display("[TB] FAIL repeat_released: got=%b want=0", key_pressed); end
    endtask

    task automatic test_extended();
        @(posedge clk); #1;
        push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
        drain(100);
        total++;
        if (key_code !== 8'h75) begin bad++; $display("[TB] FAIL ext_code: got=%h want=75", key_code); end
        total++;
        if (key_ext !== 1'b1) begin bad++; $display("[TB] FAIL ext_flag: got=%b want=1", key_ext); end
        total++;
        if (key_ascii !== 8'h00) begin bad++; $display("[TB] FAIL ext_ascii: got=%h want=00", key_ascii); end
        total++;
        if (key_pressed !== 1'b0) begin bad++; $display("[TB] FAIL ext_released: got=%b want=0", key_pressed); end
        total++;
        if (press_count !== 8'd2) begin bad++; $display("[TB] FAIL ext_count: got=%0d want=2", press_count); end
    endtask

    task automatic test_replace();
        do_reset();
        @(posedge clk); #1;
        push(8'h1C); push(8'h32); push(8'hF0); push(8'h1C);
        drain(100);
        total++;
        if (key_code !== 8'h32) begin bad++; $display("[TB] FAIL replace_code: got=%h want=32", key_code); end
        total++;
        if (key_pressed !== 1'b1) begin bad++; $display("[TB] FAIL replace_held: got=%b want=1", key_pressed); end
        total++;
        if (press_count !== 8'd2) begin bad++; $display("[TB] FAIL replace_count: got=%0d want=2", press_count); end
        total++;
        if (key_ext !== 1'b0) begin bad++; $display("[TB] FAIL replace_ext: got=%b want=0", key_ext); end
        total++;
        if (key_ascii !== exp_ascii(8'h62)) begin bad++; $display("[TB] FAIL replace_ascii: got=%h want=%h", key_ascii, exp_ascii(8'h62)); end
    endtask

    task automatic test_wrap_and_overflow();
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 255; i++) push((i % 2 == 0) ? 8'h1C : 8'h32);
        drain(2000);
        total++;
        if (press_count !== 8'd255) begin bad++; $display("[TB] FAIL wrap_preload: got=%0d want=255", press_count); end
        @(posedge clk); #1 push(8'h32);
        drain(100);
        total++;
        if (press_count !== 8'd0) begin bad++; $display("[TB] FAIL wrap_count: got=%0d want=0", press_count); end

        @(posedge clk); #1 kbd_overflow = 1'b1;
        @(posedge clk); #1 kbd_overflow = 1'b0;
        total++;
        if (err_overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_set: got=%b want=1", err_overflow); end
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (err_overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_sticky: got=%b want=1", err_overflow); end
        resetn = 1'b0;
        @(posedge clk); #1;
        total++;
        if (err_overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_reset: got=%b want=0", err_overflow); end
        resetn = 1'b1;
    endtask

    task automatic test_back_to_back();
        int pb;
        do_reset();
        pb = pop_cycles.size();
        @(posedge clk); #1;
        push(8'h1C); push(8'hF0); push(8'h1C); push(8'h29);
        drain(100);
        total++;
        if (pop_cycles.size() - pb !== 4) begin bad++; $display("[TB] FAIL b2b_pops: got=%0d want=4", pop_cycles.size() - pb); end
        for (int i = 1; i < 4; i++) begin
            if (pb + i < pop_cycles.size()) begin
                total++;
                if (pop_cycles[pb + i] - pop_cycles[pb + i - 1] !== 3) begin
                    bad++;
                    $display("[TB] FAIL b2b_spacing%0d: got=%0d want=3", i, pop_cycles[pb + i] - pop_cycles[pb + i - 1]);
                end
            end
        end
        total++;
        if (double_low !== 0) begin bad++; $display("[TB] FAIL b2b_double_low: got=%0d want=0", double_low); end
        total++;
        if ({key_code, press_count} !== {8'h29, 8'd2}) begin bad++; $display("[TB] FAIL b2b_result: got=%h want=2902", {key_code, press_count}); end
        total++;
        if (key_ascii !== exp_ascii(8'h20)) begin bad++; $display("[TB] FAIL b2b_ascii: got=%h want=%h", key_ascii, exp_ascii(8'h20)); end
    endtask

    task automatic test_reset_mid_pop();
        int n;
        @(posedge clk); #1 kbd_overflow = 1'b1;
        @(posedge clk); #1 kbd_overflow = 1'b0;
        push(8'h32);
        n = 0;
        @(negedge clk);
        while (kbd_nextdata_n !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (kbd_nextdata_n !== 1'b0) begin bad++; $display("[TB] FAIL midpop_reach: got=%b want=0", kbd_nextdata_n); end
        resetn = 1'b0;
        @(posedge clk); #1;
        total++;
        if (kbd_nextdata_n !== 1'b1) begin bad++; $display("[TB] FAIL midpop_nextdata_n: got=%b want=1", kbd_nextdata_n); end
        total++;
        if ({key_code, key_ascii, press_count} !== 24'h0) begin bad++; $display("[TB] FAIL midpop_bytes: got=%h want=000000", {key_code, key_ascii, press_count}); end
        total++;
        if ({key_ext, key_pressed, key_valid, err_overflow} !== 4'b0) begin bad++; $display("[TB] FAIL midpop_flags: got=%b want=0000", {key_ext, key_pressed, key_valid, err_overflow}); end
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        // The aborted byte is gone; a fresh press must decode normally.
        @(posedge clk); #1 push(8'h1A);
        drain(100);
        total++;
        if ({key_code, press_count, key_pressed} !== {8'h1A, 8'd1, 1'b1}) begin bad++; $display("[TB] FAIL midpop_recover: got=%h want=1a011", {key_code, press_count, key_pressed}); end
        total++;
        if (key_ascii !== exp_ascii(8'h7A)) begin bad++; $display("[TB] FAIL midpop_ascii: got=%h want=%h", key_ascii, exp_ascii(8'h7A)); end
    endtask

    initial begin
        test_reset();
        test_first_press();
        test_typematic();
        test_extended();
        test_replace();
        test_wrap_and_overflow();
        test_back_to_back();
        test_reset_mid_pop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
